// File: rtl/scan_code_filter.sv
// PS/2 scan-code filter: strips F0 break sequences, tags E0-prefixed make codes
// and queues surviving {ext,code} entries in a first-word fall-through FIFO.
module scan_code_filter #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_key,
  input  logic       clr_ovf,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_empty,
  output logic       key_full,
  output logic       overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK
  } state_t;

  state_t             state;
  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic       is_f0;
  logic       is_e0;
  logic       make_push;
  logic       make_ext;
  logic       do_pop;
  logic       do_push;
  logic       drop;
  logic [8:0] head;

  assign is_f0     = (rx_data == 8'hF0);
  assign is_e0     = (rx_data == 8'hE0);
  // A make code survives only when it is neither a prefix nor the byte after F0
  assign make_push = rx_done_tick && !is_f0 && !is_e0 && (state != S_BRK);
  assign make_ext  = (state == S_EXT);

  assign key_empty = (count == '0);
  assign key_full  = (count == CNT_FULL);

  // When full, a simultaneous pop frees the slot the push needs
  assign do_pop  = rd_key && !key_empty;
  assign do_push = make_push && (!key_full || do_pop);
  assign drop    = make_push && key_full && !do_pop;

  assign head     = mem[rd_ptr];
  assign key_code = key_empty ? 8'h00 : head[7:0];
  assign key_ext  = key_empty ? 1'b0  : head[8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (rx_done_tick) begin
      case (state)
        S_IDLE: begin
          if (is_f0)      state <= S_BRK;
          else if (is_e0) state <= S_EXT;
          else            state <= S_IDLE;
        end
        S_EXT: begin
          if (is_f0)      state <= S_BRK;
          else if (is_e0) state <= S_EXT;
          else            state <= S_IDLE;
        end
        S_BRK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {make_ext, rx_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A fresh drop outranks a clear arriving in the same cycle
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_code_filter.sv
// Directed, table-driven bench for scan_code_filter with hand-computed expectations
// plus hand-written reset-in-the-middle sequences.
module tb_scan_code_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_key;
  logic       clr_ovf;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_empty;
  logic       key_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic [7:0] e_code;
    logic       e_ext;
  } vec_t;

  vec_t vecs[$];

  scan_code_filter #(.FIFO_AW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rd_key       (rd_key),
    .clr_ovf      (clr_ovf),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_empty    (key_empty),
    .key_full     (key_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, returns 1ns after the capturing edge with inputs idle
  task automatic applyStimulus(input logic tick, input logic [7:0] data,
                               input logic rd, input logic clr);
    rx_done_tick = tick;
    rx_data      = data;
    rd_key       = rd;
    clr_ovf      = clr;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    rd_key       = 1'b0;
    clr_ovf      = 1'b0;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_empty, input logic e_full,
                             input logic e_ovf, input logic [7:0] e_code, input logic e_ext);
    checkField(name, "key_empty", {7'd0, key_empty}, {7'd0, e_empty});
    checkField(name, "key_full",  {7'd0, key_full},  {7'd0, e_full});
    checkField(name, "overflow",  {7'd0, overflow},  {7'd0, e_ovf});
    checkField(name, "key_code",  key_code,          e_code);
    checkField(name, "key_ext",   {7'd0, key_ext},   {7'd0, e_ext});
  endtask

  task automatic addVec(input logic tick, input logic [7:0] data, input logic rd,
                        input logic clr, input logic e_empty, input logic e_full,
                        input logic e_ovf, input logic [7:0] e_code, input logic e_ext);
    vec_t v;
    v.tick = tick; v.data = data; v.rd = rd; v.clr = clr;
    v.e_empty = e_empty; v.e_full = e_full; v.e_ovf = e_ovf;
    v.e_code = e_code; v.e_ext = e_ext;
    vecs.push_back(v);
  endtask

  initial begin
    //     tick data   rd clr  empty full ovf code   ext
    // Single make then pop
    addVec(1, 8'h1C, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);
    // Make + break of A leaves one entry
    addVec(1, 8'h1C, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(1, 8'hF0, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(1, 8'h1C, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);
    // Extended make + extended break
    addVec(1, 8'hE0, 0, 0,   1,   0,   0, 8'h00, 0);
    addVec(1, 8'h75, 0, 0,   0,   0,   0, 8'h75, 1);
    addVec(1, 8'hE0, 0, 0,   0,   0,   0, 8'h75, 1);
    addVec(1, 8'hF0, 0, 0,   0,   0,   0, 8'h75, 1);
    addVec(1, 8'h75, 0, 0,   0,   0,   0, 8'h75, 1);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);
    // Fill, overflow, drain in order, clear
    addVec(1, 8'h16, 0, 0,   0,   0,   0, 8'h16, 0);
    addVec(1, 8'h1E, 0, 0,   0,   0,   0, 8'h16, 0);
    addVec(1, 8'h26, 0, 0,   0,   0,   0, 8'h16, 0);
    addVec(1, 8'h25, 0, 0,   0,   1,   0, 8'h16, 0);
    addVec(1, 8'h2E, 0, 0,   0,   1,   1, 8'h16, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   1, 8'h1E, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   1, 8'h26, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   1, 8'h25, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   1, 8'h00, 0);
    addVec(0, 8'h00, 0, 1,   1,   0,   0, 8'h00, 0);
    // Full with simultaneous push and pop
    addVec(1, 8'h15, 0, 0,   0,   0,   0, 8'h15, 0);
    addVec(1, 8'h1D, 0, 0,   0,   0,   0, 8'h15, 0);
    addVec(1, 8'h24, 0, 0,   0,   0,   0, 8'h15, 0);
    addVec(1, 8'h2D, 0, 0,   0,   1,   0, 8'h15, 0);
    addVec(1, 8'h45, 1, 0,   0,   1,   0, 8'h1D, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h24, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h2D, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h45, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);
    // Drop and clear in the same cycle: set wins; unstrobed byte ignored
    addVec(1, 8'h1C, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(1, 8'h32, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(1, 8'h21, 0, 0,   0,   0,   0, 8'h1C, 0);
    addVec(1, 8'h23, 0, 0,   0,   1,   0, 8'h1C, 0);
    addVec(1, 8'h2B, 0, 1,   0,   1,   1, 8'h1C, 0);
    addVec(0, 8'h00, 0, 1,   0,   1,   0, 8'h1C, 0);
    addVec(0, 8'h1C, 0, 0,   0,   1,   0, 8'h1C, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h32, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h21, 0);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h23, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);
    // Repeated E0 prefixes still tag the make code
    addVec(1, 8'hE0, 0, 0,   1,   0,   0, 8'h00, 0);
    addVec(1, 8'hE0, 0, 0,   1,   0,   0, 8'h00, 0);
    addVec(1, 8'h74, 0, 0,   0,   0,   0, 8'h74, 1);
    // Typematic repeat is queued again
    addVec(1, 8'h74, 0, 0,   0,   0,   0, 8'h74, 1);
    addVec(0, 8'h00, 1, 0,   0,   0,   0, 8'h74, 0);
    addVec(0, 8'h00, 1, 0,   1,   0,   0, 8'h00, 0);

    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    rd_key       = 1'b0;
    clr_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1, 0, 0, 8'h00, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].tick, vecs[i].data, vecs[i].rd, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                  vecs[i].e_ovf, vecs[i].e_code, vecs[i].e_ext);
    end

    // Reset after F0 with an entry queued: entry lost, break state cleared
    applyStimulus(1, 8'h1C, 0, 0);
    applyStimulus(1, 8'hF0, 0, 0);
    #2 reset = 1'b1;
    #1 checkOutput("rst_after_f0", 1, 0, 0, 8'h00, 0);
    @(negedge clk) reset = 1'b0;
    applyStimulus(1, 8'h1C, 0, 0);
    checkOutput("fresh_after_f0", 0, 0, 0, 8'h1C, 0);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("pop_after_f0", 1, 0, 0, 8'h00, 0);

    // Push into an empty FIFO while rd_key is high keeps the entry
    applyStimulus(1, 8'h1C, 1, 0);
    checkOutput("push_pop_empty", 0, 0, 0, 8'h1C, 0);

    // Reset after E0: next make is not extended, prior entry lost
    applyStimulus(1, 8'hE0, 0, 0);
    #2 reset = 1'b1;
    #1 checkOutput("rst_after_e0", 1, 0, 0, 8'h00, 0);
    @(negedge clk) reset = 1'b0;
    applyStimulus(1, 8'h1B, 0, 0);
    checkOutput("fresh_after_e0", 0, 0, 0, 8'h1B, 0);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("pop_after_e0", 1, 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
